audio_avg_filter: RTL

//  Moving-average low-pass (noise-reduction) stage between the audio_codec read and write sides.

---
 rtl/audio_avg_filter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/audio_avg_filter.sv
// Stereo moving-average (2**LOG2_N taps) noise filter between the codec ADC and DAC FIFOs.
// One sample in flight at a time: IDLE -> RD -> CALC -> LOAD -> WR.

module audio_avg_chan #(
  parameter int unsigned DW     = 24,
  parameter int unsigned LOG2_N = 3
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              latch_i,
  input  logic              update_i,
  input  logic [LOG2_N-1:0] ptr_i,
  input  logic [DW-1:0]     sample_i,
  output logic [DW-1:0]     new_o,
  output logic [DW-1:0]     mean_o
);

  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned SW = DW + LOG2_N;

  logic [DW-1:0] new_q, new_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] hist_q [N];
  logic [DW-1:0] hist_d [N];
  logic [SW-1:0] new_ext_c;
  logic [SW-1:0] old_ext_c;

  // Sign-extend both operands so the running sum stays exact in two's complement.
  assign new_ext_c = {{LOG2_N{new_q[DW-1]}}, new_q};
  assign old_ext_c = {{LOG2_N{hist_q[ptr_i][DW-1]}}, hist_q[ptr_i]};

  always_comb begin
    new_d  = new_q;
    sum_d  = sum_q;
    hist_d = hist_q;
    if (latch_i) begin
      new_d = sample_i;
    end
    if (update_i) begin
      sum_d         = sum_q + new_ext_c - old_ext_c;
      hist_d[ptr_i] = new_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      new_q <= '0;
      sum_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      new_q  <= new_d;
      sum_q  <= sum_d;
      hist_q <= hist_d;
    end
  end

  assign new_o  = new_q;
  // Dropping the low LOG2_N bits of a signed sum is an arithmetic shift (floor).
  assign mean_o = sum_q[SW-1:LOG2_N];

endmodule

module audio_avg_filter #(
  parameter int unsigned DW     = 24,
  parameter int unsigned LOG2_N = 3
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          filter_en,
  input  logic          read_ready,
  input  logic [DW-1:0] readdata_left,
  input  logic [DW-1:0] readdata_right,
  output logic          read,
  input  logic          write_ready,
  output logic          write,
  output logic [DW-1:0] writedata_left,
  output logic [DW-1:0] writedata_right
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [LOG2_N-1:0] ptr_q, ptr_d;
  logic [DW-1:0]     wdl_q, wdl_d;
  logic [DW-1:0]     wdr_q, wdr_d;
  logic              latch_c;
  logic              update_c;
  logic [DW-1:0]     new_l, new_r;
  logic [DW-1:0]     mean_l, mean_r;

  assign latch_c  = (state_q == S_RD);
  assign update_c = (state_q == S_CALC);

  // Both channels share one history pointer so their windows stay aligned.
  audio_avg_chan #(.DW(DW), .LOG2_N(LOG2_N)) u_chan_l (
    .clk_i    (CLOCK_50),
    .rstn_i   (resetn),
    .latch_i  (latch_c),
    .update_i (update_c),
    .ptr_i    (ptr_q),
    .sample_i (readdata_left),
    .new_o    (new_l),
    .mean_o   (mean_l)
  );

  audio_avg_chan #(.DW(DW), .LOG2_N(LOG2_N)) u_chan_r (
    .clk_i    (CLOCK_50),
    .rstn_i   (resetn),
    .latch_i  (latch_c),
    .update_i (update_c),
    .ptr_i    (ptr_q),
    .sample_i (readdata_right),
    .new_o    (new_r),
    .mean_o   (mean_r)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      wdl_q   <= '0;
      wdr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wdl_q   <= wdl_d;
      wdr_q   <= wdr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wdl_d   = wdl_q;
    wdr_d   = wdr_q;
    case (state_q)
      S_IDLE: begin
        if (read_ready) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = S_CALC;
      end
      S_CALC: begin
        // N is a power of two, so natural overflow is the modulo-N wrap.
        ptr_d   = ptr_q + LOG2_N'(1);
        state_d = S_LOAD;
      end
      S_LOAD: begin
        wdl_d   = filter_en ? mean_l : new_l;
        wdr_d   = filter_en ? mean_r : new_r;
        state_d = S_WR;
      end
      S_WR: begin
        if (write_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign read            = (state_q == S_RD);
  assign write           = (state_q == S_WR) && write_ready;
  assign writedata_left  = wdl_q;
  assign writedata_right = wdr_q;

endmodule
